riscv_bp_table: RTL

RISCV_BP_TABLE -- requirements
Module: riscv_bp_table

---
 rtl/riscv_bp_table.sv | 109 ++++++++++
 1 files changed

// File: rtl/riscv_bp_table.sv
// Branch prediction table: 2-bit saturating counters indexed by
// {global history, PC window}. Sweeps every entry to weakly-not-taken
// after reset, then serves registered lookups and branch-unit updates.
module riscv_bp_table #(
    parameter int XLEN           = 32,
    parameter int BP_GLOBAL_BITS = 2,
    parameter int BP_LOCAL_BITS  = 10,
    parameter int HAS_RVC        = 0
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      if_stall,
    input  logic [XLEN-1:0]           if_pc,
    input  logic [BP_GLOBAL_BITS-1:0] bu_bp_history,
    input  logic [XLEN-1:0]           upd_pc,
    input  logic [1:0]                bu_bp_predict,
    input  logic                      bu_bp_btaken,
    input  logic                      bu_bp_update,
    output logic [1:0]                if_bp_predict,
    output logic                      bp_ready
);

    localparam int LSB   = (HAS_RVC != 0) ? 1 : 2;
    localparam int IDX_W = BP_GLOBAL_BITS + BP_LOCAL_BITS;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] sweep_q;
    logic [1:0]       bp_mem [DEPTH];

    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       upd_val;
    logic             upd_en;
    logic             sweep_last;
    logic             unused_pc_bits;

    assign lookup_idx = {bu_bp_history, if_pc[BP_LOCAL_BITS+LSB-1:LSB]};
    assign upd_idx    = {bu_bp_history, upd_pc[BP_LOCAL_BITS+LSB-1:LSB]};
    assign sweep_last = (sweep_q == '1);

    // PC bits outside the index window do not take part in the lookup
    assign unused_pc_bits = ^{if_pc[XLEN-1:BP_LOCAL_BITS+LSB], if_pc[LSB-1:0],
                              upd_pc[XLEN-1:BP_LOCAL_BITS+LSB], upd_pc[LSB-1:0]};

    // Saturating counter step derived from the originally predicted value
    always_comb begin
        upd_val = bu_bp_predict;
        if (bu_bp_btaken) begin
            if (bu_bp_predict != 2'b11) upd_val = bu_bp_predict + 2'd1;
        end else begin
            if (bu_bp_predict != 2'b00) upd_val = bu_bp_predict - 2'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= INIT;
        else       state_q <= state_d;
    end

    // Next-state and control decode
    always_comb begin
        state_d  = state_q;
        bp_ready = 1'b0;
        upd_en   = 1'b0;
        case (state_q)
            INIT: begin
                if (sweep_last) state_d = RUN;
            end
            RUN: begin
                bp_ready = 1'b1;
                upd_en   = bu_bp_update;
            end
            default: state_d = INIT;
        endcase
    end

    // Initialisation sweep counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                sweep_q <= '0;
        else if (state_q == INIT) sweep_q <= sweep_q + 1'b1;
    end

    // Counter table: sweep writes during INIT, branch updates during RUN
    always_ff @(posedge clk) begin
        if (state_q == INIT) bp_mem[sweep_q] <= 2'b01;
        else if (upd_en)     bp_mem[upd_idx] <= upd_val;
    end

    // Registered prediction; a same-cycle update to the looked-up entry is forwarded
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            if_bp_predict <= '0;
        end else if (state_q == INIT) begin
            if_bp_predict <= '0;
        end else if (!if_stall) begin
            if (upd_en && (upd_idx == lookup_idx)) if_bp_predict <= upd_val;
            else                                   if_bp_predict <= bp_mem[lookup_idx];
        end
    end

endmodule
